// File: rtl/mem_seq_arbiter.sv
// mem_seq_arbiter
//   Shares one single-port memory between the CPU's instruction-fetch and data
//   ports. Each instruction is sequenced as
//   FETCH -> DECODE (decoder settle) -> optional DATA -> COMMIT.
//   The single-cycle CPU is frozen through cpu_ce except during the one COMMIT
//   cycle, when its PC/regfile/data-memory side effects take place.
//
//   A watchdog bounds every memory request. If no ack arrives in time, the
//   transaction is forced to complete and the sticky bus_err flag is set.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   pc                     CPU program counter (fetch address)
//   dm_cs, dm_r, dm_w      CPU data-memory strobes
//   maddr, mwdata          CPU data address / store data
//   inst, mrdata           registered instruction / load data back to the CPU
//   cpu_ce                 CPU clock enable, high only in COMMIT
//   mem_req, mem_we        memory request / write enable
//   mem_addr, mem_wdata    memory address / write data
//   mem_rdata, mem_ack     memory read data and single-cycle completion
//   bus_err, err_clr       sticky timeout flag and its clear
//   instret                retired-instruction counter
module mem_seq_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_W      = 8,
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        dm_cs,
  input  logic        dm_r,
  input  logic        dm_w,
  input  logic [31:0] maddr,
  input  logic [31:0] mwdata,
  output logic [31:0] inst,
  output logic [31:0] mrdata,
  output logic        cpu_ce,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  input  logic        err_clr,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_DATA   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  // The watchdog counts 0..TIMEOUT-1 while waiting; the timeout fires in the
  // cycle whose count is TIMEOUT-1, i.e. after TIMEOUT cycles without ack.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        mrdata_q, mrdata_d;
  logic [31:0]        instret_q, instret_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic               bus_err_q, bus_err_d;

  logic               busy;
  logic               to_hit;
  logic               done;

  // A write is selected by dm_w alone; dm_r carries no extra information.
  logic               unused_dm_r;
  assign unused_dm_r = dm_r;

  assign busy   = (state_q == S_FETCH) || (state_q == S_DATA);
  // An ack in the timeout cycle takes priority over the forced completion.
  assign to_hit = busy && !mem_ack && (wdog_q == TO_LAST);
  assign done   = busy && (mem_ack || to_hit);

  // State register and all other flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      inst_q    <= RESET_INST;
      mrdata_q  <= 32'h0;
      instret_q <= 32'h0;
      wdog_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      mrdata_q  <= mrdata_d;
      instret_q <= instret_d;
      wdog_q    <= wdog_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (done) state_d = S_DECODE;
      S_DECODE: state_d = dm_cs ? S_DATA : S_COMMIT;
      S_DATA:   if (done) state_d = S_COMMIT;
      S_COMMIT: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Memory request and CPU enable outputs.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    cpu_ce    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_DATA: begin
        mem_req   = 1'b1;
        mem_we    = dm_w;
        mem_addr  = maddr;
        mem_wdata = mwdata;
      end
      S_COMMIT: cpu_ce = 1'b1;
      default: ;
    endcase
  end

  // Captured data, watchdog, error flag and retire counter.
  always_comb begin
    inst_d    = inst_q;
    mrdata_d  = mrdata_q;
    instret_d = instret_q;
    wdog_d    = '0;
    bus_err_d = bus_err_q;

    if ((state_q == S_FETCH) && done)
      inst_d = mem_ack ? mem_rdata : RESET_INST;

    // Writes leave mrdata untouched, whether acked or timed out.
    if ((state_q == S_DATA) && done && !dm_w)
      mrdata_d = mem_ack ? mem_rdata : 32'h0;

    // Cleared outside FETCH/DATA, so every entry starts from zero.
    if (busy && !done)
      wdog_d = wdog_q + CNT_W'(1);

    if (to_hit)
      bus_err_d = 1'b1;
    else if (err_clr)
      bus_err_d = 1'b0;

    if (state_q == S_COMMIT)
      instret_d = instret_q + 32'd1;
  end

  assign inst    = inst_q;
  assign mrdata  = mrdata_q;
  assign instret = instret_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_seq_arbiter.sv
module tb_mem_seq_arbiter;

  localparam logic [31:0] R_INST = 32'h0000_0013;
  localparam logic [31:0] LW     = 32'h0802_A083;
  localparam logic [31:0] SW     = 32'h0410_2023;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        dm_cs, dm_r, dm_w;
  logic [31:0] maddr, mwdata;
  logic [31:0] inst, mrdata;
  logic        cpu_ce, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        bus_err, err_clr;
  logic [31:0] instret;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_seq_arbiter #(
    .TIMEOUT   (4),
    .CNT_W     (8),
    .RESET_INST(R_INST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .dm_cs    (dm_cs),
    .dm_r     (dm_r),
    .dm_w     (dm_w),
    .maddr    (maddr),
    .mwdata   (mwdata),
    .inst     (inst),
    .mrdata   (mrdata),
    .cpu_ce   (cpu_ce),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .bus_err  (bus_err),
    .err_clr  (err_clr),
    .instret  (instret)
  );

  // One rising edge passes; we land just after the following falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = 32'h0; dm_cs = 0; dm_r = 0; dm_w = 0;
    maddr = 32'h0; mwdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b1; err_clr = 0;
    tick(); tick();
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_mem_req: got %h exp 0", mem_req); end
    vec++; if (cpu_ce !== 1'b0) begin errs++; $display("FAIL rst_cpu_ce: got %h exp 0", cpu_ce); end
    vec++; if (inst !== R_INST) begin errs++; $display("FAIL rst_inst: got %h exp %h", inst, R_INST); end
    vec++; if (mrdata !== 32'h0) begin errs++; $display("FAIL rst_mrdata: got %h exp 0", mrdata); end
    vec++; if (bus_err !== 1'b0) begin errs++; $display("FAIL rst_bus_err: got %h exp 0", bus_err); end
    vec++; if (instret !== 32'h0) begin errs++; $display("FAIL rst_instret: got %h exp 0", instret); end
    reset = 1'b0;
    #1;
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL idle_mem_req: got %h exp 0", mem_req); end
  endtask

  task automatic test_nop_stream();
    pc = 32'h0000_1000; mem_rdata = 32'h0; mem_ack = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vec++; if (cpu_ce !== (i % 3 == 0)) begin errs++; $display("FAIL nop_cpu_ce[%0d]: got %h exp %h", i, cpu_ce, (i % 3 == 0)); end
      vec++; if (mem_req !== (i % 3 == 1)) begin errs++; $display("FAIL nop_mem_req[%0d]: got %h exp %h", i, mem_req, (i % 3 == 1)); end
    end
    mem_ack = 1'b0;
    tick();
    vec++; if (instret !== 32'd4) begin errs++; $display("FAIL nop_instret: got %0d exp 4", instret); end
    vec++; if (inst !== 32'h0) begin errs++; $display("FAIL nop_inst: got %h exp 0", inst); end
    vec++; if (mem_addr !== 32'h0000_1000) begin errs++; $display("FAIL nop_fetch_addr: got %h exp 00001000", mem_addr); end
  endtask

  task automatic test_load();
    pc = 32'h100; mem_rdata = LW; mem_ack = 1'b1;
    dm_cs = 1; dm_r = 1; dm_w = 0; maddr = 32'h80; mwdata = 32'h5555;
    #1;
    vec++; if (mem_addr !== 32'h100) begin errs++; $display("FAIL ld_fetch_addr: got %h exp 00000100", mem_addr); end
    tick();
    vec++; if (inst !== LW) begin errs++; $display("FAIL ld_inst: got %h exp %h", inst, LW); end
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL ld_decode_req: got %h exp 0", mem_req); end
    mem_ack = 1'b0; mem_rdata = 32'h1111_1111;
    tick();
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL ld_data_req: got %h exp 1", mem_req); end
    vec++; if (mem_we !== 1'b0) begin errs++; $display("FAIL ld_we: got %h exp 0", mem_we); end
    vec++; if (mem_addr !== 32'h80) begin errs++; $display("FAIL ld_addr: got %h exp 00000080", mem_addr); end
    tick(); tick();
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL ld_wait_req: got %h exp 1", mem_req); end
    vec++; if (mrdata !== 32'h0) begin errs++; $display("FAIL ld_mrdata_hold: got %h exp 0", mrdata); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    vec++; if (cpu_ce !== 1'b1) begin errs++; $display("FAIL ld_commit_ce: got %h exp 1", cpu_ce); end
    vec++; if (mrdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ld_mrdata: got %h exp deadbeef", mrdata); end
    vec++; if (bus_err !== 1'b0) begin errs++; $display("FAIL ld_bus_err: got %h exp 0", bus_err); end
    tick();
    vec++; if (instret !== 32'd5) begin errs++; $display("FAIL ld_instret: got %0d exp 5", instret); end
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL ld_next_fetch: got %h exp 1", mem_req); end
  endtask

  task automatic test_store();
    mem_rdata = SW; mem_ack = 1'b1;
    dm_cs = 1; dm_r = 1; dm_w = 1; maddr = 32'h40; mwdata = 32'h1234;
    tick();
    vec++; if (inst !== SW) begin errs++; $display("FAIL st_inst: got %h exp %h", inst, SW); end
    mem_rdata = 32'hCAFE_F00D;
    tick();
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL st_req: got %h exp 1", mem_req); end
    vec++; if (mem_we !== 1'b1) begin errs++; $display("FAIL st_we: got %h exp 1", mem_we); end
    vec++; if (mem_addr !== 32'h40) begin errs++; $display("FAIL st_addr: got %h exp 00000040", mem_addr); end
    vec++; if (mem_wdata !== 32'h1234) begin errs++; $display("FAIL st_wdata: got %h exp 00001234", mem_wdata); end
    tick();
    vec++; if (mrdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL st_mrdata_kept: got %h exp deadbeef", mrdata); end
    vec++; if (cpu_ce !== 1'b1) begin errs++; $display("FAIL st_commit_ce: got %h exp 1", cpu_ce); end
    tick();
    vec++; if (instret !== 32'd6) begin errs++; $display("FAIL st_instret: got %0d exp 6", instret); end
    mem_ack = 1'b0;
  endtask

  task automatic test_fetch_timeout();
    dm_cs = 0; dm_r = 0; dm_w = 0;
    repeat (3) tick();
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL to_wait_req: got %h exp 1", mem_req); end
    vec++; if (bus_err !== 1'b0) begin errs++; $display("FAIL to_early_err: got %h exp 0", bus_err); end
    tick();
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL to_forced_req: got %h exp 0", mem_req); end
    vec++; if (inst !== R_INST) begin errs++; $display("FAIL to_inst: got %h exp %h", inst, R_INST); end
    vec++; if (bus_err !== 1'b1) begin errs++; $display("FAIL to_bus_err: got %h exp 1", bus_err); end
    tick();
    vec++; if (cpu_ce !== 1'b1) begin errs++; $display("FAIL to_commit_ce: got %h exp 1", cpu_ce); end
    tick();
    vec++; if (instret !== 32'd7) begin errs++; $display("FAIL to_instret: got %0d exp 7", instret); end
    err_clr = 1'b1;
    tick();
    vec++; if (bus_err !== 1'b0) begin errs++; $display("FAIL to_err_clr: got %h exp 0", bus_err); end
    tick(); tick();
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL to2_wait_req: got %h exp 1", mem_req); end
    tick();
    vec++; if (bus_err !== 1'b1) begin errs++; $display("FAIL to2_set_wins: got %h exp 1", bus_err); end
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL to2_forced_req: got %h exp 0", mem_req); end
    err_clr = 1'b0;
  endtask

  task automatic test_data_timeout();
    dm_cs = 1; dm_w = 0; err_clr = 1'b1;
    tick();
    vec++; if (bus_err !== 1'b0) begin errs++; $display("FAIL dto_clr: got %h exp 0", bus_err); end
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL dto_req: got %h exp 1", mem_req); end
    err_clr = 1'b0;
    repeat (3) tick();
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL dto_wait_req: got %h exp 1", mem_req); end
    tick();
    vec++; if (mrdata !== 32'h0) begin errs++; $display("FAIL dto_mrdata: got %h exp 0", mrdata); end
    vec++; if (bus_err !== 1'b1) begin errs++; $display("FAIL dto_bus_err: got %h exp 1", bus_err); end
    vec++; if (cpu_ce !== 1'b1) begin errs++; $display("FAIL dto_commit_ce: got %h exp 1", cpu_ce); end
    dm_cs = 0;
    tick();
    vec++; if (instret !== 32'd8) begin errs++; $display("FAIL dto_instret: got %0d exp 8", instret); end
  endtask

  task automatic test_ack_at_timeout();
    err_clr = 1'b1;
    tick();
    vec++; if (bus_err !== 1'b0) begin errs++; $display("FAIL aat_clr: got %h exp 0", bus_err); end
    err_clr = 1'b0;
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    vec++; if (inst !== 32'h0BAD_F00D) begin errs++; $display("FAIL aat_inst: got %h exp 0badf00d", inst); end
    vec++; if (bus_err !== 1'b0) begin errs++; $display("FAIL aat_bus_err: got %h exp 0", bus_err); end
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL aat_req: got %h exp 0", mem_req); end
    mem_ack = 1'b0;
  endtask

  task automatic test_instret_wrap();
    dm_cs = 0;
    tick();
    vec++; if (cpu_ce !== 1'b1) begin errs++; $display("FAIL wrap_commit_ce: got %h exp 1", cpu_ce); end
    tick();
    vec++; if (instret !== 32'd9) begin errs++; $display("FAIL wrap_pre_instret: got %0d exp 9", instret); end
    force dut.instret_q = 32'hFFFF_FFFF;
    tick();
    release dut.instret_q;
    #1;
    vec++; if (instret !== 32'hFFFF_FFFF) begin errs++; $display("FAIL wrap_preload: got %h exp ffffffff", instret); end
    mem_ack = 1'b1; mem_rdata = 32'h0;
    tick(); tick(); tick();
    vec++; if (instret !== 32'h0) begin errs++; $display("FAIL wrap_instret: got %h exp 0", instret); end
  endtask

  task automatic test_reset_mid_data();
    mem_rdata = LW; dm_cs = 1; dm_w = 0; maddr = 32'h200;
    tick();
    mem_ack = 1'b0;
    tick();
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rmd_pre_req: got %h exp 1", mem_req); end
    reset = 1'b1;
    #1;
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rmd_req: got %h exp 0", mem_req); end
    vec++; if (cpu_ce !== 1'b0) begin errs++; $display("FAIL rmd_ce: got %h exp 0", cpu_ce); end
    vec++; if (instret !== 32'h0) begin errs++; $display("FAIL rmd_instret: got %h exp 0", instret); end
    vec++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL rmd_addr: got %h exp 0", mem_addr); end
    tick();
    reset = 1'b0; mem_ack = 1'b1;
    #1;
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rmd_idle_req: got %h exp 0", mem_req); end
    tick();
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rmd_fetch_req: got %h exp 1", mem_req); end
    vec++; if (mem_addr !== pc) begin errs++; $display("FAIL rmd_fetch_addr: got %h exp %h", mem_addr, pc); end
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_load();
    test_store();
    test_fetch_timeout();
    test_data_timeout();
    test_ack_at_timeout();
    test_instret_wrap();
    test_reset_mid_data();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
